// File: rtl/serial_addsub_nb_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package serial_addsub_nb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Counter must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_addsub_nb_add_slice.sv
// Combinational ripple of DIGIT full-adder cells; also exposes the carry into its top bit.
module add_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    sum      = '0;
    c_msb_in = 1'b0;
    c        = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub_nb.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, start/busy/done handshake.
module serial_addsub_nb
  import serial_addsub_nb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT-1:0]       sl_sum;
  logic                   sl_cout, sl_cmsb;
  logic [WIDTH+DIGIT-1:0] shift_cat;

  add_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (opa_q[DIGIT-1:0]),
    .b        (opb_q[DIGIT-1:0]),
    .cin      (carry_q),
    .sum      (sl_sum),
    .cout     (sl_cout),
    .c_msb_in (sl_cmsb)
  );

  // Concatenate-then-slice keeps the shift legal when DIGIT == WIDTH.
  assign shift_cat = {sl_sum, psum_q};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        psum_d  = shift_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = sl_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          sum_d   = shift_cat[WIDTH+DIGIT-1:DIGIT];
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_nb.sv
// Directed bench for serial_addsub_nb at 8x1 and 16x4 digit configurations.
module tb_serial_addsub_nb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub_nb #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub_nb #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit w16, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci);
    if (w16) begin
      a16 = a; b16 = b; sub16 = s; cin16 = ci; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = s; cin8 = ci; start8 = 1'b1;
    end
  endtask

  // Clocks the accepting edge, then waits (bounded) for done and checks the result.
  task automatic finish_op(input bit w16, input int n, input logic [15:0] es,
                           input logic ec, input logic eo, input string tag);
    int cyc;
    int bcnt;
    tick();
    start8 = 1'b0;
    start16 = 1'b0;
    cyc = 0;
    bcnt = (w16 ? busy16 : busy8) ? 1 : 0;
    while (!(w16 ? done16 : done8) && cyc < 40) begin
      tick();
      cyc++;
      if (w16 ? busy16 : busy8) bcnt++;
    end
    chk(32'(cyc), 32'(n), {tag, ".latency"});
    chk(32'(bcnt), 32'(n), {tag, ".busy_cycles"});
    chk(w16 ? {16'h0, sum16} : {24'h0, sum8}, {16'h0, es}, {tag, ".sum"});
    chk({31'h0, w16 ? cout16 : cout8}, {31'h0, ec}, {tag, ".cout"});
    chk({31'h0, w16 ? ovf16 : ovf8}, {31'h0, eo}, {tag, ".ovf"});
  endtask

  initial begin
    int dones;
    int dcyc;

    #12;
    chk({24'h0, sum8}, 32'h0, "rst.sum8");
    chk({28'h0, busy8, done8, cout8, ovf8}, 32'h0, "rst.flags8");
    chk({16'h0, sum16}, 32'h0, "rst.sum16");
    chk({28'h0, busy16, done16, cout16, ovf16}, 32'h0, "rst.flags16");
    @(negedge clk) rst_n = 1'b1;
    tick();

    apply(0, 16'h3C, 16'h0F, 1'b0, 1'b0);
    finish_op(0, 8, 16'h4B, 1'b0, 1'b0, "add_3c_0f");
    tick();
    chk({31'h0, done8}, 32'h0, "add_3c_0f.pulse_width");

    apply(0, 16'hFF, 16'h01, 1'b0, 1'b0);
    finish_op(0, 8, 16'h00, 1'b1, 1'b0, "add_ff_01");
    apply(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    finish_op(0, 8, 16'h80, 1'b0, 1'b1, "add_7f_01");
    apply(0, 16'h80, 16'h80, 1'b0, 1'b0);
    finish_op(0, 8, 16'h00, 1'b1, 1'b1, "add_80_80");
    apply(0, 16'h05, 16'h07, 1'b1, 1'b0);
    finish_op(0, 8, 16'hFE, 1'b0, 1'b0, "sub_05_07");
    apply(0, 16'h80, 16'h01, 1'b1, 1'b0);
    finish_op(0, 8, 16'h7F, 1'b1, 1'b1, "sub_80_01");
    apply(0, 16'h05, 16'h07, 1'b1, 1'b1);
    finish_op(0, 8, 16'hFE, 1'b0, 1'b0, "sub_cin_ignored");

    apply(1, 16'h1234, 16'h0FCD, 1'b0, 1'b1);
    finish_op(1, 4, 16'h2202, 1'b0, 1'b0, "w16_add");
    apply(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    finish_op(1, 4, 16'h0000, 1'b1, 1'b0, "w16_b2b");
    tick();
    chk({31'h0, done16}, 32'h0, "w16_b2b.pulse_width");

    // A second start three cycles into the operation must be ignored.
    apply(0, 16'h3C, 16'h0F, 1'b0, 1'b0);
    tick();
    start8 = 1'b0;
    dones = 0;
    dcyc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1; start8 = 1'b1;
      end
      if (c == 4) start8 = 1'b0;
      tick();
      if (c == 5) chk({24'h0, sum8}, 32'hFE, "busy_start.sum_held");
      if (done8) begin
        dones++;
        dcyc = c;
        chk({24'h0, sum8}, 32'h4B, "busy_start.sum");
        chk({30'h0, cout8, ovf8}, 32'h0, "busy_start.flags");
      end
    end
    chk(32'(dones), 32'd1, "busy_start.done_count");
    chk(32'(dcyc), 32'd8, "busy_start.latency");

    apply(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk({24'h0, sum8}, 32'h0, "midrst.sum");
    chk({28'h0, busy8, done8, cout8, ovf8}, 32'h0, "midrst.flags");
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done8) dones++;
    end
    chk(32'(dones), 32'd0, "midrst.no_done");
    chk({31'h0, busy8}, 32'h0, "midrst.idle");
    apply(0, 16'h80, 16'h01, 1'b1, 1'b0);
    finish_op(0, 8, 16'h7F, 1'b1, 1'b1, "post_rst_sub");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub_nb.md
Name: serial_addsub_nb

Overview:
- Parametrised digit-serial adder/subtractor. Processes DIGIT bits per clock through a ripple slice of full-adder cells, with a registered carry between digits.
- Successor to the combinational single-bit full-adder cell. Adds operand width, digit width, a subtract mode, signed-overflow detection and a start/busy/done handshake.
- Sits beside the datapath as an area-lean arithmetic unit for multi-cycle ALU operations.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH. N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in for add mode
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when results update
- sum  output  WIDTH  result; held until the next completion
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers and digit counter cleared.
- States: IDLE, RUN.
  - IDLE→RUN on start=1.
  - RUN→IDLE after the N-th digit edge.
  - No other transitions.
- Capture at the accepted start edge (edge k):
  - opA ← a
  - opB ← sub ? ~b : b
  - carry ← sub ? 1 : cin
  - counter ← 0
  - busy ← 1
- RUN, each edge k+1..k+N:
  - Slice adds opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Digit result shifts into the top of the partial-sum register.
  - opA and opB shift right by DIGIT.
  - carry ← slice carry out.
  - counter increments.
- Completion at edge k+N:
  - sum ← final partial sum.
  - cout ← final carry.
  - ovf ← carry-in to bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - done=1 for exactly one cycle; busy ← 0.
- Latency: done is high in the cycle after edge k+N, i.e. N cycles after start is accepted. busy is high for N cycles.
- start while busy=1: ignored; no effect on the operation in flight.
- start high in the done cycle: accepted (busy=0 then). Back-to-back throughput is one result per N cycles. Operands must be valid at that edge.
- a, b, sub, cin: sampled only at an accepted start; later changes are ignored.
- sum/cout/ovf: never show partial values; they change only at completion edges.
- Reset mid-operation: operation discarded, all outputs return to reset values, no done pulse.
- DIGIT = WIDTH: N=1, done one cycle after start. Behaves as a registered one-shot adder.
- Arithmetic is modulo 2^WIDTH. ovf is meaningful for signed interpretation and cout for unsigned.

Decomposition:
- Shared arithmetic package/header holds:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1
  - the counter-width helper, $clog2(N+1)
- Sub-module add_slice (parameter DIGIT): combinational ripple of DIGIT full-adder cells.
  - Inputs: a, b, cin.
  - Outputs: sum[DIGIT], cout, c_msb_in (carry into its top bit, used for ovf on the last digit).
- The top level holds the FSM, shift registers, counter and output registers.

Test Plan:
- WIDTH=8, DIGIT=1, add 0x3C+0x0F, cin=0 → done pulse 8 cycles after start; sum=0x4B, cout=0, ovf=0; busy high for exactly 8 cycles.
- Add 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then 0x7F+0x01 → sum=0x80, cout=0, ovf=1. Then 0x80+0x80 → sum=0x00, cout=1, ovf=1.
- sub=1: 0x05-0x07 → sum=0xFE, cout=0, ovf=0. 0x80-0x01 → sum=0x7F, cout=1, ovf=1. cin=1 applied in sub mode has no effect.
- WIDTH=16, DIGIT=4: 0x1234+0x0FCD, cin=1 → done 4 cycles after start; sum=0x2202, cout=0. Back-to-back start in the done cycle with 0xFFFF+0x0001 → second done 4 cycles later; sum=0x0000, cout=1.
- Start pulsed again at cycle 3 of an 8-cycle op with different operands → ignored; first result correct, only one done.
- rst_n low at cycle 4 of an operation → outputs 0 immediately (asynchronous); no done pulse. A fresh start after release completes correctly.
